delta_spike_aer_encoder: RTL

Converts the round-robin spike stream from the multichannel delta modulator into address-event (AER) words and buffers them in a FIFO for the downstream spiking core or host link. One input beat arrives per channel per frame, in channel order. The block tags every positive or negative spike with its channel index, polarity and a frame timestamp. It drops events with accounting when the FIFO is full.

---
 rtl/delta_spike_aer_encoder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/delta_spike_aer_encoder.sv
// ---------------------------------------------------------------------------
// delta_spike_aer_encoder
//
// Turns the round-robin spike stream of the multichannel delta modulator into
// address-event words {timestamp, polarity, channel} and queues them in a
// first-word-fall-through FIFO for the downstream spiking core / host link.
// One input beat arrives per channel per frame, in channel order 0..CHANNELS-1.
// Events that find the FIFO full are discarded and counted.
//
// Ports
//   clk         in   clock
//   rst         in   synchronous, active-high reset
//   pos_spike   in   positive spike for the current channel beat
//   neg_spike   in   negative spike for the current channel beat
//   valid       in   one channel beat; spike inputs only meaningful while high
//   ev_data     out  head event word {ts, polarity(1=pos), channel}
//   ev_valid    out  FIFO head holds an event
//   ev_ready    in   consumer takes the head when ev_valid && ev_ready
//   frame_done  out  one-cycle pulse after the beat of channel CHANNELS-1
//   overflow    out  sticky, set once any event has been dropped
//   drop_cnt    out  saturating count of dropped events
//   fifo_level  out  current FIFO occupancy
//
// FIFO_DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module delta_spike_aer_encoder #(
  parameter  int CHANNELS   = 16,
  parameter  int TS_WIDTH   = 8,
  parameter  int FIFO_DEPTH = 32,
  parameter  int DROP_W     = 16,
  localparam int CH_W       = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS),
  localparam int EV_W       = TS_WIDTH + 1 + CH_W,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pos_spike,
  input  logic              neg_spike,
  input  logic              valid,
  output logic [EV_W-1:0]   ev_data,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Frame position and timestamp
  logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  // FIFO storage and bookkeeping
  logic [EV_W-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;

  // Registered outputs
  logic [EV_W-1:0]     ev_data_q, ev_data_d;
  logic                ev_valid_q, ev_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  // Per-cycle decode
  logic                last_ch_s;
  logic                event_s;
  logic [EV_W-1:0]     ev_word_s;
  logic                pop_s;
  logic                full_s;
  logic                push_s;
  logic                drop_s;
  logic [LVL_W-1:0]    remain_s;

  // Decode the current beat and the push/pop/drop decision
  always_comb begin
    last_ch_s = (ch_cnt_q == CH_W'(CHANNELS - 1));
    event_s   = valid && (pos_spike || neg_spike);
    // Both spikes at once is illegal upstream; polarity follows pos_spike so
    // it collapses to a single positive event.
    ev_word_s = {ts_q, pos_spike, ch_cnt_q};
    pop_s     = ev_valid_q && ev_ready;
    full_s    = (level_q == LVL_W'(FIFO_DEPTH));
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    push_s    = event_s && (!full_s || pop_s);
    drop_s    = event_s && !push_s;
  end

  // Channel counter and frame timestamp
  always_comb begin
    ch_cnt_d     = ch_cnt_q;
    ts_d         = ts_q;
    frame_done_d = 1'b0;
    if (valid) begin
      frame_done_d = last_ch_s;
      if (last_ch_s) begin
        // Explicit wrap so non-power-of-two channel counts work.
        ch_cnt_d = {CH_W{1'b0}};
        ts_d     = ts_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        ch_cnt_d = ch_cnt_q + {{(CH_W-1){1'b0}}, 1'b1};
      end
    end else begin
      ch_cnt_d = ch_cnt_q;
    end
  end

  // FIFO pointers, occupancy and the registered head word
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    ev_data_d  = {EV_W{1'b0}};
    ev_valid_d = 1'b0;
    remain_s   = level_q - LVL_W'(pop_s);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + {{(LVL_W-1){1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{(LVL_W-1){1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase

    // The head is held in a register so ev_data stays put during a stall.
    // When nothing older survives this cycle, the word being pushed becomes
    // the head directly since it is not yet readable from storage.
    if (level_d == {LVL_W{1'b0}}) begin
      ev_data_d  = {EV_W{1'b0}};
      ev_valid_d = 1'b0;
    end else if (remain_s == {LVL_W{1'b0}}) begin
      ev_data_d  = ev_word_s;
      ev_valid_d = 1'b1;
    end else begin
      ev_data_d  = mem_q[rd_ptr_d];
      ev_valid_d = 1'b1;
    end
  end

  // Drop accounting: sticky flag and saturating counter
  always_comb begin
    overflow_d = overflow_q | drop_s;
    if (drop_s && (drop_cnt_q != {DROP_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + {{(DROP_W-1){1'b0}}, 1'b1};
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_q     <= {CH_W{1'b0}};
      ts_q         <= {TS_WIDTH{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      level_q      <= {LVL_W{1'b0}};
      ev_data_q    <= {EV_W{1'b0}};
      ev_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= {DROP_W{1'b0}};
    end else begin
      ch_cnt_q     <= ch_cnt_d;
      ts_q         <= ts_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ev_data_q    <= ev_data_d;
      ev_valid_q   <= ev_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Event storage; contents are don't-care until referenced by the pointers
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= ev_word_s;
    end
  end

  assign ev_data    = ev_data_q;
  assign ev_valid   = ev_valid_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign fifo_level = level_q;

endmodule
